// File: rtl/key_schedule_sequencer.sv
// Key schedule sequencer: loads a 1024-bit key and 128-bit tweak, then streams
// subkeys 0..20 over a valid/ready handshake and pulses done_o after the last one.
// Subkey words are formed from rotating copies of the key and tweak registers.
// Each acceptance rotates both by one position, so word i always reads kr[i]
// and no wide 17-way index mux is needed.
module key_schedule_sequencer (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_valid_i,
  output logic          start_ready_o,
  input  logic [1023:0] key_i,
  input  logic [127:0]  tweak_i,
  output logic [1023:0] subkey_o,
  output logic [4:0]    subkey_idx_o,
  output logic          subkey_valid_o,
  input  logic          subkey_ready_i,
  output logic          done_o
);

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  localparam logic [63:0] KEY_PARITY_CONST = 64'h1BD11BDAA9FC1A22;
  localparam logic [4:0]  LAST_IDX         = 5'd20;

  state_t      state;
  logic [4:0]  s;
  logic [63:0] kr [17];
  logic [63:0] tr [3];
  logic [63:0] key_parity;
  logic        load_accept;
  logic        advance;

  assign load_accept  = (state == IDLE) && start_valid_i;
  assign advance      = (state == EMIT) && subkey_ready_i;
  assign subkey_idx_o = s;

  // Extended key word k16: constant XOR-folded with all sixteen key words.
  always_comb begin
    // NOTE: combinational blocks use blocking '=' so the running XOR accumulates
    // in order within the block; sequential blocks below use '<=' only.
    key_parity = KEY_PARITY_CONST;
    for (int j = 0; j < 16; j++) begin
      key_parity = key_parity ^ key_i[64*j +: 64];
    end
  end

  // Control FSM: state, subkey index and the registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      s              <= '0;
      start_ready_o  <= 1'b1;
      subkey_valid_o <= 1'b0;
      done_o         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_o <= 1'b0;
          if (start_valid_i) begin
            state          <= EMIT;
            s              <= '0;
            start_ready_o  <= 1'b0;
            subkey_valid_o <= 1'b1;
          end
        end
        EMIT: begin
          if (subkey_ready_i) begin
            if (s == LAST_IDX) begin
              state          <= IDLE;
              s              <= '0;
              start_ready_o  <= 1'b1;
              subkey_valid_o <= 1'b0;
              done_o         <= 1'b1;
            end else begin
              s <= s + 5'd1;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Key/tweak datapath: capture on load, rotate by one word per accepted subkey.
  always_ff @(posedge clk) begin
    // NOTE: these wide data registers are deliberately not reset; subkey_o is
    // gated by subkey_valid_o, which is reset, so stale contents never escape.
    if (load_accept) begin
      for (int j = 0; j < 16; j++) begin
        kr[j] <= key_i[64*j +: 64];
      end
      kr[16] <= key_parity;
      tr[0]  <= tweak_i[63:0];
      tr[1]  <= tweak_i[127:64];
      tr[2]  <= tweak_i[63:0] ^ tweak_i[127:64];
    end else if (advance) begin
      for (int j = 0; j < 16; j++) begin
        kr[j] <= kr[j+1];
      end
      kr[16] <= kr[0];
      tr[0]  <= tr[1];
      tr[1]  <= tr[2];
      tr[2]  <= tr[0];
    end
  end

  // Subkey assembly: rotated key words plus tweak/index injection in words 13-15.
  always_comb begin
    // NOTE: default assignment first so every path drives subkey_o (no latch).
    subkey_o = '0;
    if (subkey_valid_o) begin
      for (int i = 0; i < 16; i++) begin
        subkey_o[64*i +: 64] = kr[i];
      end
      subkey_o[13*64 +: 64] = kr[13] + tr[0];
      subkey_o[14*64 +: 64] = kr[14] + tr[1];
      subkey_o[15*64 +: 64] = kr[15] + {59'd0, s};
    end
  end

endmodule
